// File: rtl/rs_frame_rx.sv
// rs_frame_rx: 8N1 UART character receiver that groups bytes into idle-gap delimited
// frames and checks each frame with CRC-16/MODBUS (residue zero on a good frame).

module rs_frame_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int GAP_BITS     = 35,
    parameter int MAX_LEN      = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_end,
    output logic [8:0] frame_len,
    output logic       crc_ok,
    output logic       framing_error,
    output logic       overflow
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W   = $clog2(GAP_CYC + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(GAP_CYC);
    localparam logic [8:0]       LEN_LIMIT = 9'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             rxMeta_q, rxs_q, rxsPrev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic [15:0]      crc_q, crc_d;
    logic [8:0]       lenCnt_q, lenCnt_d;
    logic             bad_q, bad_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic [7:0]       byteData_q, byteData_d;
    logic             byteValid_q, byteValid_d;
    logic             frameEnd_q, frameEnd_d;
    logic [8:0]       frameLen_q, frameLen_d;
    logic             crcOk_q, crcOk_d;
    logic             framingErr_q, framingErr_d;
    logic             overflow_q, overflow_d;

    logic             startEdge;
    logic [15:0]      crcNew;
    logic [8:0]       lenNew;

    // Bytewise reflected CRC-16 (poly 0xA001), all eight shifts unrolled in one cycle.
    function automatic logic [15:0] crcUpdate(input logic [15:0] crcIn, input logic [7:0] data);
        logic [15:0] c;
        c = crcIn ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign startEdge = rxsPrev_q & ~rxs_q;
    assign crcNew    = crcUpdate(crc_q, shift_q);
    assign lenNew    = lenCnt_q + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q     <= 1'b1;
            rxs_q        <= 1'b1;
            rxsPrev_q    <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            crc_q        <= 16'hFFFF;
            lenCnt_q     <= '0;
            bad_q        <= 1'b0;
            gap_q        <= '0;
            byteData_q   <= '0;
            byteValid_q  <= 1'b0;
            frameEnd_q   <= 1'b0;
            frameLen_q   <= '0;
            crcOk_q      <= 1'b0;
            framingErr_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            rxMeta_q     <= rx;
            rxs_q        <= rxMeta_q;
            rxsPrev_q    <= rxs_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitIdx_q     <= bitIdx_d;
            shift_q      <= shift_d;
            crc_q        <= crc_d;
            lenCnt_q     <= lenCnt_d;
            bad_q        <= bad_d;
            gap_q        <= gap_d;
            byteData_q   <= byteData_d;
            byteValid_q  <= byteValid_d;
            frameEnd_q   <= frameEnd_d;
            frameLen_q   <= frameLen_d;
            crcOk_q      <= crcOk_d;
            framingErr_q <= framingErr_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitIdx_d     = bitIdx_q;
        shift_d      = shift_q;
        crc_d        = crc_q;
        lenCnt_d     = lenCnt_q;
        bad_d        = bad_q;
        gap_d        = gap_q;
        byteData_d   = byteData_q;
        byteValid_d  = 1'b0;
        frameEnd_d   = 1'b0;
        frameLen_d   = frameLen_q;
        crcOk_d      = crcOk_q;
        framingErr_d = 1'b0;
        overflow_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                bitIdx_d = '0;
                if (startEdge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    shift_d  = {rxs_q, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Leave at mid-stop-bit so the next start edge is never missed.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rxs_q) begin
                        framingErr_d = 1'b1;
                        bad_d        = 1'b1;
                    end else if (lenCnt_q < LEN_LIMIT) begin
                        byteValid_d = 1'b1;
                        byteData_d  = shift_q;
                        crc_d       = crcNew;
                        lenCnt_d    = lenNew;
                        frameLen_d  = lenNew;
                        crcOk_d     = (crcNew == 16'h0000) && (lenNew >= 9'd3) && !bad_q;
                    end else begin
                        overflow_d = 1'b1;
                        bad_d      = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A start edge landing on the saturating cycle still closes the old frame first.
        if (state_q == S_IDLE) begin
            if (startEdge) begin
                gap_d = '0;
            end else if (rxs_q && (gap_q != GAP_MAX)) begin
                gap_d = gap_q + GAP_W'(1);
            end
            if ((gap_q == GAP_LAST) && (rxs_q || startEdge) && ((lenCnt_q != 9'd0) || bad_q)) begin
                frameEnd_d = 1'b1;
                frameLen_d = lenCnt_q;
                crcOk_d    = (crc_q == 16'h0000) && (lenCnt_q >= 9'd3) && !bad_q;
                crc_d      = 16'hFFFF;
                lenCnt_d   = '0;
                bad_d      = 1'b0;
            end
        end
    end

    assign byte_data     = byteData_q;
    assign byte_valid    = byteValid_q;
    assign frame_end     = frameEnd_q;
    assign frame_len     = frameLen_q;
    assign crc_ok        = crcOk_q;
    assign framing_error = framingErr_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_rs_frame_rx.sv
// tb_rs_frame_rx: drives serial characters into two receivers (full and 4-byte MAX_LEN)
// and compares every strobe against a transaction-level frame model.

module tb_rs_frame_rx;

    localparam int CPB  = 16;
    localparam int GAPB = 35;
    localparam int MAXS = 4;
    localparam int MAXF = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx1;
    logic [7:0] bd0, bd1;
    logic       bv0, bv1, fe0, fe1, ok0, ok1, ferr0, ferr1, ov0, ov1;
    logic [8:0] fl0, fl1;

    always #5 clk = ~clk;

    rs_frame_rx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAPB), .MAX_LEN(MAXF)) dutFull (
        .clk(clk), .rst(rst), .rx(rx0),
        .byte_data(bd0), .byte_valid(bv0), .frame_end(fe0), .frame_len(fl0),
        .crc_ok(ok0), .framing_error(ferr0), .overflow(ov0)
    );

    rs_frame_rx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAPB), .MAX_LEN(MAXS)) dutSmall (
        .clk(clk), .rst(rst), .rx(rx1),
        .byte_data(bd1), .byte_valid(bv1), .frame_end(fe1), .frame_len(fl1),
        .crc_ok(ok1), .framing_error(ferr1), .overflow(ov1)
    );

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0]  expByte0[$];
    logic [7:0]  expByte1[$];
    int          expFrame0[$];
    int          expFrame1[$];
    logic [7:0]  frameBuf[$];
    int          curLen[2];
    logic [15:0] curCrc[2];
    bit          curBad[2];
    int          expFe[2];
    int          expOv[2];
    int          seenFe[2];
    int          seenOv[2];
    int          lastLen[2];
    int          lastOk[2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] refCrc(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            if (r[0]) r = (r >> 1) ^ 16'hA001;
            else      r = r >> 1;
        end
        return r;
    endfunction

    task automatic modelClear(input int sel);
        curLen[sel] = 0;
        curCrc[sel] = 16'hFFFF;
        curBad[sel] = 1'b0;
    endtask

    task automatic modelByte(input int sel, input logic [7:0] b, input bit stopGood);
        if (!stopGood) begin
            expFe[sel]++;
            curBad[sel] = 1'b1;
        end else if (curLen[sel] < ((sel == 1) ? MAXS : MAXF)) begin
            if (sel == 0) expByte0.push_back(b);
            else          expByte1.push_back(b);
            curLen[sel]++;
            curCrc[sel] = refCrc(curCrc[sel], b);
        end else begin
            expOv[sel]++;
            curBad[sel] = 1'b1;
        end
    endtask

    task automatic modelFrameEnd(input int sel);
        int rec;
        if ((curLen[sel] > 0) || curBad[sel]) begin
            rec = (curLen[sel] << 1) | ((curCrc[sel] == 16'h0000 && curLen[sel] >= 3 && !curBad[sel]) ? 1 : 0);
            if (sel == 0) expFrame0.push_back(rec);
            else          expFrame1.push_back(rec);
        end
        modelClear(sel);
    endtask

    task automatic setRx(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic waitBits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] b, input bit stopGood);
        modelByte(sel, b, stopGood);
        setRx(sel, 1'b0);
        waitBits(1);
        for (int i = 0; i < 8; i++) begin
            setRx(sel, b[i]);
            waitBits(1);
        end
        setRx(sel, stopGood);
        waitBits(1);
        setRx(sel, 1'b1);
    endtask

    // Long idles always close the frame; short ones never do.
    task automatic idleBits(input int sel, input int n);
        if (n >= GAPB + 2) modelFrameEnd(sel);
        waitBits(n);
        if (n >= GAPB + 2) begin
            checkOutput("drainBytes", (sel == 0) ? expByte0.size() : expByte1.size(), 0);
            checkOutput("drainFrames", (sel == 0) ? expFrame0.size() : expFrame1.size(), 0);
        end
    endtask

    task automatic sendFrameBuf(input int sel, input int intraMax);
        foreach (frameBuf[i]) begin
            applyStimulus(sel, frameBuf[i], 1'b1);
            if (intraMax > 0) waitBits($urandom_range(0, intraMax));
        end
    endtask

    task automatic appendCrc();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (frameBuf[i]) c = refCrc(c, frameBuf[i]);
        frameBuf.push_back(c[7:0]);
        frameBuf.push_back(c[15:8]);
    endtask

    task automatic loadModbusFrame();
        frameBuf = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    endtask

    always @(negedge clk) begin
        if (bv0) begin
            checkOutput("byteExpected0", 32'(expByte0.size() != 0), 32'd1);
            if (expByte0.size() != 0) checkOutput("byteData0", 32'(bd0), 32'(expByte0.pop_front()));
        end
        if (bv1) begin
            checkOutput("byteExpected1", 32'(expByte1.size() != 0), 32'd1);
            if (expByte1.size() != 0) checkOutput("byteData1", 32'(bd1), 32'(expByte1.pop_front()));
        end
        if (fe0) begin : frame0
            int e;
            lastLen[0] = int'(fl0);
            lastOk[0]  = int'(ok0);
            checkOutput("frameExpected0", 32'(expFrame0.size() != 0), 32'd1);
            if (expFrame0.size() != 0) begin
                e = expFrame0.pop_front();
                checkOutput("frameLen0", 32'(fl0), 32'(e >> 1));
                checkOutput("crcOk0", 32'(ok0), 32'(e & 1));
            end
        end
        if (fe1) begin : frame1
            int e;
            lastLen[1] = int'(fl1);
            lastOk[1]  = int'(ok1);
            checkOutput("frameExpected1", 32'(expFrame1.size() != 0), 32'd1);
            if (expFrame1.size() != 0) begin
                e = expFrame1.pop_front();
                checkOutput("frameLen1", 32'(fl1), 32'(e >> 1));
                checkOutput("crcOk1", 32'(ok1), 32'(e & 1));
            end
        end
        if (ferr0) seenFe[0]++;
        if (ferr1) seenFe[1]++;
        if (ov0)   seenOv[0]++;
        if (ov1)   seenOv[1]++;
    end

    initial begin
        logic [7:0] partial;
        int         sel;
        for (int s = 0; s < 2; s++) begin
            modelClear(s);
            expFe[s] = 0; expOv[s] = 0; seenFe[s] = 0; seenOv[s] = 0;
            lastLen[s] = -1; lastOk[s] = -1;
        end
        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rstByteData", 32'(bd0), 32'h00);
        checkOutput("rstByteValid", 32'(bv0), 32'd0);
        checkOutput("rstFrameEnd", 32'(fe0), 32'd0);
        checkOutput("rstFrameLen", 32'(fl0), 32'd0);
        checkOutput("rstCrcOk", 32'(ok0), 32'd0);
        checkOutput("rstFramingErr", 32'(ferr0), 32'd0);
        checkOutput("rstOverflow", 32'(ov1), 32'd0);
        rst = 1'b0;
        idleBits(0, 40);

        $display("[TB] reference Modbus frame");
        loadModbusFrame();
        sendFrameBuf(0, 0);
        idleBits(0, 40);
        checkOutput("tp1Len", lastLen[0], 8);
        checkOutput("tp1Ok", lastOk[0], 1);

        $display("[TB] corrupted byte 4");
        loadModbusFrame();
        frameBuf[3] = 8'h02;
        sendFrameBuf(0, 0);
        idleBits(0, 40);
        checkOutput("tp2Len", lastLen[0], 8);
        checkOutput("tp2Ok", lastOk[0], 0);

        $display("[TB] short glitch then good frame");
        setRx(0, 1'b0);
        repeat (CPB / 2 - 2) @(negedge clk);
        setRx(0, 1'b1);
        waitBits(3);
        checkOutput("glitchNoFe", seenFe[0], 0);
        loadModbusFrame();
        sendFrameBuf(0, 0);
        idleBits(0, 40);
        checkOutput("glitchNextOk", lastOk[0], 1);

        $display("[TB] framing error inside a frame");
        applyStimulus(0, 8'h55, 1'b0);
        waitBits(2);
        loadModbusFrame();
        sendFrameBuf(0, 0);
        idleBits(0, 40);
        checkOutput("feSeen", seenFe[0], 1);
        checkOutput("feFrameOk", lastOk[0], 0);
        checkOutput("feFrameLen", lastLen[0], 8);
        sendFrameBuf(0, 0);
        idleBits(0, 40);
        checkOutput("feRecoverOk", lastOk[0], 1);

        $display("[TB] frame of framing errors only");
        applyStimulus(0, 8'hF0, 1'b0);
        idleBits(0, 40);
        checkOutput("feOnlyLen", lastLen[0], 0);
        checkOutput("feOnlyOk", lastOk[0], 0);

        $display("[TB] two frames, 20 then 40 bit-times apart");
        loadModbusFrame();
        sendFrameBuf(0, 0);
        waitBits(20);
        frameBuf = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
        appendCrc();
        sendFrameBuf(0, 0);
        idleBits(0, 40);
        checkOutput("mergedLen", lastLen[0], 16);
        checkOutput("mergedOk", lastOk[0], 0);
        loadModbusFrame();
        sendFrameBuf(0, 0);
        idleBits(0, 40);
        checkOutput("splitLenA", lastLen[0], 8);
        checkOutput("splitOkA", lastOk[0], 1);
        frameBuf = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
        appendCrc();
        sendFrameBuf(0, 0);
        idleBits(0, 40);
        checkOutput("splitLenB", lastLen[0], 8);
        checkOutput("splitOkB", lastOk[0], 1);

        $display("[TB] reset during data bit 4");
        applyStimulus(0, 8'h01, 1'b1);
        applyStimulus(0, 8'h03, 1'b1);
        partial = 8'hA5;
        setRx(0, 1'b0);
        waitBits(1);
        for (int i = 0; i < 4; i++) begin
            setRx(0, partial[i]);
            waitBits(1);
        end
        setRx(0, partial[4]);
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        setRx(0, 1'b1);
        checkOutput("midRstLen", 32'(fl0), 32'd0);
        checkOutput("midRstData", 32'(bd0), 32'h00);
        rst = 1'b0;
        modelClear(0);
        modelClear(1);
        waitBits(5);
        loadModbusFrame();
        sendFrameBuf(0, 0);
        idleBits(0, 40);
        checkOutput("postRstLen", lastLen[0], 8);
        checkOutput("postRstOk", lastOk[0], 1);

        $display("[TB] MAX_LEN=4 receiver with 6 bytes");
        loadModbusFrame();
        frameBuf = frameBuf[0:5];
        sendFrameBuf(1, 0);
        idleBits(1, 40);
        checkOutput("maxLen", lastLen[1], 4);
        checkOutput("maxOk", lastOk[1], 0);
        checkOutput("maxOverflows", seenOv[1], 2);

        $display("[TB] randomized frames");
        for (int it = 0; it < 14; it++) begin
            int mode;
            sel = $urandom_range(0, 1);
            frameBuf.delete();
            for (int j = 0; j < $urandom_range(1, 6); j++) frameBuf.push_back(8'($urandom_range(0, 255)));
            mode = $urandom_range(0, 3);
            if (mode <= 2) appendCrc();
            if (mode == 2) frameBuf[0] = frameBuf[0] ^ 8'h10;
            if ($urandom_range(0, 5) == 0) begin
                applyStimulus(sel, 8'($urandom_range(0, 255)), 1'b0);
                waitBits($urandom_range(1, 3));
            end
            sendFrameBuf(sel, 3);
            idleBits(sel, $urandom_range(37, 45));
        end

        for (int s = 0; s < 2; s++) begin
            checkOutput("totalFramingErr", seenFe[s], expFe[s]);
            checkOutput("totalOverflow", seenOv[s], expOv[s]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/rs_frame_rx.md
# rs_frame_rx

Byte-level receiver that sits downstream of the RS-485/HDLC bridge and consumes its serial `tx` line. It deserializes 8N1 UART characters, groups them into frames delimited by a line-idle gap, and runs a CRC-16/MODBUS check over each frame. It reports each received byte, then one end-of-frame strobe carrying the frame length and the CRC/error status.

## Interface
- `CLKS_PER_BIT`, default 217: clk cycles per bit (25 MHz / 115200). Must be ≥ 4.
- `GAP_BITS`, default 35: idle bit-times that terminate a frame (3.5 characters).
- `MAX_LEN`, default 256: maximum bytes counted per frame.
- `clk` in, 1: single clock for all logic.
- `rst` in, 1: reset, synchronous and active-high.
- `rx` in, 1: serial line. Idle high. Asynchronous to `clk`.
- `byte_data` out, 8: last received byte. Valid only while `byte_valid` is high.
- `byte_valid` out, 1: one-cycle strobe per good byte.
- `frame_end` out, 1: one-cycle strobe at frame termination.
- `frame_len` out, 9: number of accepted bytes. Valid with `frame_end`.
- `crc_ok` out, 1: frame passed all checks. Valid with `frame_end`.
- `framing_error` out, 1: one-cycle strobe when a stop bit is sampled low.
- `overflow` out, 1: one-cycle strobe for each byte dropped beyond `MAX_LEN`.

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer. Both FFs reset to 1. All logic uses the synchronized `rxs`.
- **Bit FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on a high-to-low transition of `rxs`. The bit counter clears.
  - START: at `CLKS_PER_BIT/2` cycles, sample `rxs`. If it is 1, treat it as a glitch and return to IDLE with no output. If it is 0, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles. Shift bits in LSB first. After 8 samples, go to STOP.
  - STOP: sample once after `CLKS_PER_BIT` cycles.
    - Sample = 1: the byte is good.
    - Sample = 0: pulse `framing_error`, discard the byte, set the frame-bad flag.
    - Either way, return to IDLE immediately, half a bit early, for resync.
- **Good-byte handling:**
  - If `frame_len < MAX_LEN`: pulse `byte_valid`, increment `frame_len`, update the CRC.
  - Otherwise: pulse `overflow`, set frame-bad, leave the CRC and length unchanged.
- **CRC-16/MODBUS:**
  - Reflected polynomial 0xA001, initial value 0xFFFF.
  - Processes a full byte in one cycle (8 unrolled iterations).
  - The CRC is transmitted low byte first, so a correct frame leaves residue 0x0000.
- **Gap detection:**
  - The gap counter increments while the FSM is in IDLE and `rxs` = 1.
  - It clears on any start detection.
  - It saturates at `GAP_BITS*CLKS_PER_BIT`.
  - The cycle it reaches that value with `frame_len > 0` or frame-bad set: pulse `frame_end`.
- **Frame status and clearing:**
  - `crc_ok` = (residue == 0) AND (`frame_len` ≥ 3) AND NOT frame-bad.
  - The cycle after `frame_end`: CRC returns to 0xFFFF, `frame_len` clears, frame-bad clears.
  - A frame containing only framing errors yields `frame_end` with `frame_len` = 0 and `crc_ok` = 0.
- **Reset values:** all outputs 0 (`byte_data` 0x00, `frame_len` 0), FSM IDLE, CRC 0xFFFF, gap counter 0.
- **Reset mid-frame:** the partial byte and partial frame are discarded. No `frame_end` is emitted for them.

## Timing
- **Sample points:** with the detected falling edge of `rxs` at cycle E, samples occur at E + `CLKS_PER_BIT/2` + k·`CLKS_PER_BIT`.
  - k = 0: start bit.
  - k = 1..8: data bits.
  - k = 9: stop bit.
- **Byte latency:** `byte_valid`, `framing_error` and `overflow` are registered and assert at stop sample + 1.
  - The edge at the `rx` pin reaches E 2 cycles later, via the synchronizer.
- **Back-to-back bytes:** a start edge is accepted from the first IDLE cycle after the stop sample. Back-to-back characters at full rate are received with no loss.
- **Frame-end latency:** `frame_end` asserts `GAP_BITS*CLKS_PER_BIT` cycles after the FSM returns to IDLE with the line high.
  - `frame_len` and `crc_ok` are stable in that cycle.
  - They hold their values until the next `byte_valid`, then reflect the new frame.
- **Simultaneous events:** a start edge in the same cycle the gap saturates loses to the gap. `frame_end` fires first, and the new byte opens a new frame.
- **No backpressure:** the consumer must accept every strobe.

## Test plan
- Send 01 03 00 00 00 01 84 0A, then idle ≥ 35 bit-times → 8 `byte_valid` pulses with those values in order, then `frame_end` with `frame_len` = 8 and `crc_ok` = 1.
- Same frame with byte 4 changed to 0x02 → 8 bytes, `frame_len` = 8, `crc_ok` = 0.
- Low pulse on `rx` of `CLKS_PER_BIT/2 − 2` cycles → no `byte_valid`, no `framing_error`, FSM back in IDLE.
- Byte 0x55 with its stop bit driven low, followed by a valid CRC'd frame → `framing_error` pulse, `frame_end` with `crc_ok` = 0. The next frame then reports `crc_ok` = 1.
- Two frames separated by 20 bit-times of idle → a single `frame_end` with `frame_len` equal to the sum and `crc_ok` = 0. A 40-bit-time separation → two `frame_end` pulses, each with `crc_ok` = 1.
- Assert `rst` during data bit 4, then send a full valid frame → no output for the aborted byte, and the valid frame is reported correctly.
- With `MAX_LEN` = 4, send 6 bytes → 4 `byte_valid`, 2 `overflow`, `frame_len` = 4, `crc_ok` = 0.
